// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, result/forward codes and hazard FSM state
package pipe_pkg;
  localparam int ADDR_W = 5;
  localparam int RSRC_W = 2;
  localparam logic [RSRC_W-1:0] LOAD_SRC = 2'b01;
  localparam logic [RSRC_W-1:0] IMM_SRC = 2'b11;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] FWD_IMM = 2'b11;
  typedef enum logic {IDLE, BUSY} mcState_t;
endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count events, holding once every bit is set
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/forward control with multi-cycle interlock and perf counters
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int RSRC_W = pipe_pkg::RSRC_W,
  parameter logic [RSRC_W-1:0] LOAD_SRC = pipe_pkg::LOAD_SRC,
  parameter logic [RSRC_W-1:0] IMM_SRC = pipe_pkg::IMM_SRC,
  parameter int MC_MAX_LAT = 34,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1D,
  input  logic [ADDR_W-1:0] rs2D,
  input  logic [ADDR_W-1:0] rs1E,
  input  logic [ADDR_W-1:0] rs2E,
  input  logic [ADDR_W-1:0] rdE,
  input  logic [RSRC_W-1:0] resultSrcE,
  input  logic [1:0]        pcSrcE,
  input  logic              mcStartE,
  input  logic              mcDone,
  input  logic [ADDR_W-1:0] rdM,
  input  logic [ADDR_W-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic [RSRC_W-1:0] resultSrcM,
  input  logic [RSRC_W-1:0] resultSrcW,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mcBusy,
  output logic              mcTimeout,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);
  localparam int WD_W = MC_MAX_LAT > 2 ? $clog2(MC_MAX_LAT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_LAT - 2);
  mcState_t state;
  logic [WD_W-1:0] wdCnt;
  logic lw, br, stallMc;
  function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] src);
    return src == '0 ? FWD_RF :
      (src == rdM && regWriteM) ? FWD_M :
      (src == rdM && resultSrcM == IMM_SRC) ? FWD_IMM :
      (src == rdW && (regWriteW || resultSrcW == IMM_SRC)) ? FWD_W : FWD_RF;
  endfunction
  assign mcBusy = state == BUSY;
  assign lw = resultSrcE == LOAD_SRC && rdE != '0 && (rdE == rs1D || rdE == rs2D);
  assign br = pcSrcE != 2'b00 && !mcBusy;
  assign stallMc = mcBusy && !mcDone;
  // a pending multi-cycle op freezes F/D/E; otherwise a redirect outranks a load-use stall
  always_comb begin
    stallF = !rst && (stallMc || (!mcBusy && !br && lw));
    stallD = stallF;
    stallE = !rst && stallMc;
    flushM = stallE;
    flushD = !rst && br;
    flushE = !rst && !mcBusy && (br || lw);
    forwardAE = rst ? FWD_RF : fwdSel(rs1E);
    forwardBE = rst ? FWD_RF : fwdSel(rs2E);
  end
  // multi-cycle interlock with a watchdog that abandons ops that never finish
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wdCnt <= '0;
      mcTimeout <= 1'b0;
    end else if (state == IDLE) begin
      wdCnt <= '0;
      if (mcStartE && !mcDone) state <= BUSY;
    end else if (mcDone) state <= IDLE;
    else if (wdCnt == WD_LAST) begin
      state <= IDLE;
      mcTimeout <= 1'b1;
    end else wdCnt <= wdCnt + 1'b1;
  sat_counter #(.CNT_W(CNT_W)) uStallCnt (.clk(clk), .rst(rst), .inc(stallF), .count(stallCnt));
  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (.clk(clk), .rst(rst), .inc(flushD), .count(flushCnt));
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table, directed multi-cycle sequences and randomized model check
module tb_hazard_ctrl_unit;
  localparam int LAT = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] resultSrcE, pcSrcE, resultSrcM, resultSrcW, forwardAE, forwardBE;
  logic mcStartE, mcDone, regWriteM, regWriteW;
  logic stallF, stallD, stallE, flushD, flushE, flushM, mcBusy, mcTimeout;
  logic [CW-1:0] stallCnt, flushCnt;
  int tests = 0, fails = 0;
  hazard_ctrl_unit #(.MC_MAX_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultSrcE(resultSrcE), .pcSrcE(pcSrcE), .mcStartE(mcStartE), .mcDone(mcDone),
    .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .resultSrcM(resultSrcM), .resultSrcW(resultSrcW), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mcBusy(mcBusy), .mcTimeout(mcTimeout),
    .stallCnt(stallCnt), .flushCnt(flushCnt));
  always #5 clk = ~clk;
  typedef struct {
    string name;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic [1:0] rsE, pc;
    logic [4:0] rdM;
    logic rwM;
    logic [1:0] rsM;
    logic [4:0] rdW;
    logic rwW;
    logic [1:0] rsW;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clearIn;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {resultSrcE, pcSrcE, resultSrcM, resultSrcW} = '0;
    {mcStartE, mcDone, regWriteM, regWriteW} = '0;
  endtask
  task automatic doRst;
    clearIn();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic setLw;
    resultSrcE = 2'b01;
    rdE = 5'd7;
    rs2D = 5'd7;
  endtask
  function automatic logic [9:0] outs();
    return {stallF, stallD, stallE, flushD, flushE, flushM, forwardAE, forwardBE};
  endfunction
  function automatic logic [1:0] refFwd(input int src);
    if (src == 0) return 2'b00;
    if (src == int'(rdM) && regWriteM) return 2'b10;
    if (src == int'(rdM) && resultSrcM == 2'b11) return 2'b11;
    if (src == int'(rdW) && (regWriteW || resultSrcW == 2'b11)) return 2'b01;
    return 2'b00;
  endfunction
  initial begin
    int cnt, fl, mCyc, mS, mF;
    bit mBusy, mTo, sMc, brE, lwE, sF;
    logic [9:0] e;
    clearIn();
    vecs[0]  = '{"fwd_m_beats_w", 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 5, 1, 0, 10'b000000_10_00};
    vecs[1]  = '{"fwd_m_imm",     0, 0, 5, 0, 0, 0, 0, 5, 0, 3, 5, 1, 0, 10'b000000_11_00};
    vecs[2]  = '{"fwd_x0",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 10'b000000_00_00};
    vecs[3]  = '{"fwd_w_b",       0, 0, 3, 6, 0, 0, 0, 3, 1, 0, 6, 1, 0, 10'b000000_10_01};
    vecs[4]  = '{"fwd_w_imm",     0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 9, 0, 3, 10'b000000_01_01};
    vecs[5]  = '{"fwd_none",      0, 0, 4, 4, 0, 0, 0, 4, 0, 1, 4, 0, 0, 10'b000000_00_00};
    vecs[6]  = '{"lw_rs2",        0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 10'b110010_00_00};
    vecs[7]  = '{"lw_x0",         0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'b000000_00_00};
    vecs[8]  = '{"br_beats_lw",   7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 10'b000110_00_00};
    vecs[9]  = '{"br_only",       0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 10'b000110_00_00};
    vecs[10] = '{"lw_rs1",        3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 10'b110010_00_00};
    vecs[11] = '{"non_load",      7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 10'b000000_00_00};
    setLw();
    #2 check("rst_outs", 32'(outs()), 0);
    tick();
    tick();
    rst = 0;
    clearIn();
    #1 check("post_rst_state", {mcBusy, mcTimeout, stallCnt, flushCnt}, 0);
    tick();
    foreach (vecs[i]) begin
      rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E;
      rdE = vecs[i].rdE; resultSrcE = vecs[i].rsE; pcSrcE = vecs[i].pc;
      rdM = vecs[i].rdM; regWriteM = vecs[i].rwM; resultSrcM = vecs[i].rsM;
      rdW = vecs[i].rdW; regWriteW = vecs[i].rwW; resultSrcW = vecs[i].rsW;
      #2 check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      tick();
    end
    doRst();
    setLw();
    #2 check("lw_once", 32'(outs()), 32'(10'b110010_00_00));
    tick();
    clearIn();
    #1 check("lw_counts", {stallCnt, flushCnt}, {4'd1, 4'd0});
    doRst();
    setLw();
    pcSrcE = 2'b01;
    #2 check("br_lw_outs", 32'(outs()), 32'(10'b000110_00_00));
    tick();
    clearIn();
    #1 check("br_counts", {stallCnt, flushCnt}, {4'd0, 4'd1});
    doRst();
    mcStartE = 1;
    #2 check("mc_start_no_stall", {outs(), mcBusy}, 0);
    tick();
    mcStartE = 0;
    pcSrcE = 2'b01;
    cnt = 0;
    fl = 0;
    for (int k = 1; k <= 4; k++) begin
      mcDone = k == 4;
      #2 check("mc_busy", mcBusy, 1);
      cnt += int'(stallF && stallD && stallE && flushM);
      fl += int'(flushD || flushE);
      tick();
    end
    clearIn();
    check("mc_stall_cycles", cnt, 3);
    check("mc_no_flush", fl, 0);
    check("mc_idle_after", {mcBusy, stallCnt}, {1'b0, 4'd3});
    doRst();
    mcStartE = 1;
    tick();
    mcStartE = 0;
    cnt = 0;
    for (int k = 0; k < 100 && mcBusy; k++) begin
      cnt++;
      tick();
    end
    check("timeout_busy_cycles", cnt, LAT - 1);
    check("timeout_flag", {mcTimeout, mcBusy}, 2'b10);
    tick();
    check("timeout_sticky", mcTimeout, 1);
    doRst();
    check("rst_clears", {mcTimeout, stallCnt, flushCnt}, 0);
    mcStartE = 1;
    tick();
    mcStartE = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1 check("rst_mid_busy", {mcBusy, stallF, stallE}, 0);
    doRst();
    setLw();
    repeat (20) tick();
    check("stall_saturate", stallCnt, CMAX);
    doRst();
    {mBusy, mTo} = '0;
    {mCyc, mS, mF} = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 63) == 0;
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      resultSrcE = 2'($urandom_range(0, 3)); resultSrcM = 2'($urandom_range(0, 3));
      resultSrcW = 2'($urandom_range(0, 3));
      regWriteM = 1'($urandom_range(0, 1)); regWriteW = 1'($urandom_range(0, 1));
      pcSrcE = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      mcStartE = $urandom_range(0, 5) == 0;
      mcDone = $urandom_range(0, i < 1500 ? 2 : 12) == 0;
      #2;
      sMc = mBusy && !mcDone;
      brE = pcSrcE != 0 && !mBusy;
      lwE = resultSrcE == 2'b01 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      sF = !rst && (sMc || (!mBusy && !brE && lwE));
      e = rst ? '0 : {sF, sF, sMc, brE, !mBusy && (brE || lwE), sMc, refFwd(rs1E), refFwd(rs2E)};
      check("rand_outs", 32'(outs()), 32'(e));
      check("rand_state", {mcBusy, mcTimeout}, {mBusy, mTo});
      check("rand_counts", {stallCnt, flushCnt}, {mS[CW-1:0], mF[CW-1:0]});
      if (rst) begin
        {mBusy, mTo} = '0;
        {mCyc, mS, mF} = '0;
      end else begin
        if (sF && mS < CMAX) mS++;
        if (brE && mF < CMAX) mF++;
        if (!mBusy) begin
          if (mcStartE && !mcDone) begin
            mBusy = 1;
            mCyc = 1;
          end
        end else if (mcDone) mBusy = 0;
        else if (mCyc == LAT - 1) begin
          mBusy = 0;
          mTo = 1;
        end else mCyc++;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
